// File: rtl/iq_in_formatter_if.sv
// -----------------------------------------------------------------------------
// iq_in_formatter_if
//
// AXI-Stream style IQ beat interface between iq_in_formatter and the FM
// receiver core.  One beat carries one complex sample.
//
//   TDATA  [31:0]  {Q[15:0], I[15:0]}, each Q1.15
//   TVALID         beat present
//   TREADY         sink accepts the beat
//
// Modports:
//   master - the formatter (drives TDATA/TVALID, reads TREADY)
//   slave  - the receiver  (reads TDATA/TVALID, drives TREADY)
// -----------------------------------------------------------------------------
interface iq_in_formatter_if;
   logic [31:0] TDATA;
   logic        TVALID;
   logic        TREADY;

   modport master (
      output TDATA,
      output TVALID,
      input  TREADY
   );

   modport slave (
      input  TDATA,
      input  TVALID,
      output TREADY
   );
endinterface

// File: rtl/iq_in_formatter.sv
// -----------------------------------------------------------------------------
// iq_in_formatter
//
// Front end of the FM receiver: captures signed ADC I/Q pairs on a sample
// strobe, scales them to Q1.15, discards a settling prefix after enable,
// buffers the samples in a small first-word-fall-through FIFO and presents
// them as an AXI-Stream beat {Q,I}.  Samples that arrive while the FIFO is
// full are dropped and counted.
//
// Optional build macro:
//   IQ_IN_DC_REMOVE_EN - inserts a first-order DC blocker per channel ahead
//                        of the capture register.  Undefined by default.
//
// Ports:
//   ap_clk      in   clock
//   ap_rst_n    in   asynchronous active-low reset
//   en          in   capture enable
//   adc_valid   in   one-cycle strobe qualifying adc_i / adc_q
//   adc_i       in   ADC_W signed in-phase sample
//   adc_q       in   ADC_W signed quadrature sample
//   iq_out_V    if   master side of the IQ stream (TDATA/TVALID/TREADY)
//   clr_ovf     in   synchronous clear of the overflow status
//   ovf_sticky  out  set on any dropped sample
//   ovf_count   out  16-bit saturating dropped-sample count
//   state_o     out  00 IDLE, 01 PRIME, 10 RUN
//
// Parameters:
//   ADC_W       ADC sample width, 8..16
//   FIFO_DEPTH  FIFO entries, power of two, >= 2
//   PRIME_CNT   strobes discarded after enable (0 = none)
// -----------------------------------------------------------------------------
module iq_in_formatter #(
   parameter int ADC_W      = 12,
   parameter int FIFO_DEPTH = 8,
   parameter int PRIME_CNT  = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    en,
   input  logic                    adc_valid,
   input  logic signed [ADC_W-1:0] adc_i,
   input  logic signed [ADC_W-1:0] adc_q,
   iq_in_formatter_if.master       iq_out_V,
   input  logic                    clr_ovf,
   output logic                    ovf_sticky,
   output logic [15:0]             ovf_count,
   output logic [1:0]              state_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // Prime counter must hold the value PRIME_CNT-1; keep at least one bit
   // so the PRIME_CNT = 0 build still elaborates.
   localparam int PCW   = (PRIME_CNT > 0) ? $clog2(PRIME_CNT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRIME = 2'b01,
      ST_RUN   = 2'b10
   } state_t;

   state_t             state_reg;
   logic [PCW-1:0]     prime_cnt_reg;

   // {Q,I} after scaling (and DC removal when built in)
   logic [31:0]        y_pack;

   logic               st1_valid_reg;
   logic [31:0]        st1_data_reg;
   logic               capture;

   logic [31:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W:0]     occ_reg;
   logic [PTR_W:0]     occ_next;
   logic               tvalid;
   logic               pop;
   logic               push;
   logic               drop;

   logic               ovf_sticky_reg;
   logic [15:0]        ovf_count_reg;

   // -------------------------------------------------------------------------
   // Per-channel scaling (channel 0 = I, channel 1 = Q)
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic signed [ADC_W-1:0] adc_sel;
         logic signed [15:0]      s_ch;

         assign adc_sel = (gi == 0) ? adc_i : adc_q;
         // Left-justify into Q1.15: sign extend, then zero-fill the LSBs.
         assign s_ch    = 16'(adc_sel) << (16 - ADC_W);

`ifdef IQ_IN_DC_REMOVE_EN
         logic signed [25:0] acc_reg;
         logic signed [25:0] acc_next;
         logic signed [15:0] dc_est;
         logic signed [16:0] y_unsat;
         logic        [15:0] y_sat;

         assign dc_est   = 16'(acc_reg >>> 10);
         assign y_unsat  = 17'(s_ch) - 17'(dc_est);
         // Bits 16 and 15 disagree only when the difference left Q1.15.
         assign y_sat    = (y_unsat[16] != y_unsat[15]) ?
                           (y_unsat[16] ? 16'h8000 : 16'h7FFF) :
                           y_unsat[15:0];
         assign acc_next = acc_reg + 26'(y_unsat) - 26'(dc_est);

         // en low in PRIME/RUN sends the FSM to IDLE on this edge, so the
         // accumulator is cleared with it; in IDLE it simply stays zero.
         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               acc_reg <= '0;
            end else if (!en) begin
               acc_reg <= '0;
            end else if (adc_valid && (state_reg != ST_IDLE)) begin
               acc_reg <= acc_next;
            end
         end

         assign y_pack[gi*16 +: 16] = y_sat;
`else
         assign y_pack[gi*16 +: 16] = s_ch;
`endif
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Control FSM: IDLE -> (PRIME) -> RUN, any state -> IDLE when en drops.
   // -------------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg     <= ST_IDLE;
         prime_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               prime_cnt_reg <= '0;
               if (en) begin
                  state_reg <= (PRIME_CNT == 0) ? ST_RUN : ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (!en) begin
                  state_reg <= ST_IDLE;
               end else if (adc_valid) begin
                  prime_cnt_reg <= prime_cnt_reg + 1'b1;
                  if (prime_cnt_reg == PCW'(PRIME_CNT - 1)) begin
                     state_reg <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (!en) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign state_o = state_reg;

   // -------------------------------------------------------------------------
   // Stage 1 capture register.  A strobe coinciding with en falling is not
   // captured, hence the explicit en term.
   // -------------------------------------------------------------------------
   assign capture = adc_valid && en && (state_reg == ST_RUN);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         st1_valid_reg <= 1'b0;
         st1_data_reg  <= '0;
      end else begin
         st1_valid_reg <= capture;
         if (capture) begin
            st1_data_reg <= y_pack;
         end
      end
   end

   // -------------------------------------------------------------------------
   // First-word-fall-through FIFO.  The head entry is read combinationally so
   // a write is visible on TDATA the cycle after it lands; the storage has no
   // reset because the pointers alone define what is valid.
   // -------------------------------------------------------------------------
   assign tvalid = (occ_reg != '0);
   assign pop    = tvalid && iq_out_V.TREADY;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push   = st1_valid_reg &&
                   ((occ_reg != (PTR_W+1)'(FIFO_DEPTH)) || pop);
   assign drop   = st1_valid_reg && !push;

   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + 1'b1;
         2'b01:   occ_next = occ_reg - 1'b1;
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= st1_data_reg;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         occ_reg <= occ_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // TDATA is forced to zero while no beat is offered so reset and drained
   // states present a clean bus.
   assign iq_out_V.TVALID = tvalid;
   assign iq_out_V.TDATA  = tvalid ? fifo_mem[rd_ptr_reg] : '0;

   // -------------------------------------------------------------------------
   // Overflow status.  A drop in the clearing cycle is counted as the first
   // event after the clear.
   // -------------------------------------------------------------------------
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ovf_sticky_reg <= 1'b0;
         ovf_count_reg  <= '0;
      end else if (clr_ovf) begin
         ovf_sticky_reg <= drop;
         ovf_count_reg  <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         ovf_sticky_reg <= 1'b1;
         if (ovf_count_reg != 16'hFFFF) begin
            ovf_count_reg <= ovf_count_reg + 16'd1;
         end
      end
   end

   assign ovf_sticky = ovf_sticky_reg;
   assign ovf_count  = ovf_count_reg;

endmodule

// File: tb/tb_iq_in_formatter.sv
// -----------------------------------------------------------------------------
// tb_iq_in_formatter
//
// Two formatter instances share one stimulus stream: instance 0 built with
// PRIME_CNT = 0, instance 1 with PRIME_CNT = 16.  A queue-based model of the
// sample path is stepped on every clock edge and compared with both
// instances on every falling edge; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iq_in_formatter;
   localparam int ADC_W = 12;
   localparam int DEPTH = 8;
   localparam int NDUT  = 2;

   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   logic en = 1'b0;
   logic adc_valid = 1'b0;
   logic clr_ovf = 1'b0;
   logic tready = 1'b0;
   logic signed [ADC_W-1:0] adc_i = '0;
   logic signed [ADC_W-1:0] adc_q = '0;

   logic [31:0] tdata_o    [NDUT];
   logic        tvalid_o   [NDUT];
   logic        sticky_o   [NDUT];
   logic [15:0] ovfcnt_o   [NDUT];
   logic [1:0]  state_out  [NDUT];

   always #5 ap_clk = ~ap_clk;

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         iq_in_formatter_if u_if ();
         assign u_if.TREADY  = tready;
         assign tdata_o[gi]  = u_if.TDATA;
         assign tvalid_o[gi] = u_if.TVALID;

         iq_in_formatter #(
            .ADC_W      (ADC_W),
            .FIFO_DEPTH (DEPTH),
            .PRIME_CNT  ((gi == 0) ? 0 : 16)
         ) u_dut (
            .ap_clk     (ap_clk),
            .ap_rst_n   (ap_rst_n),
            .en         (en),
            .adc_valid  (adc_valid),
            .adc_i      (adc_i),
            .adc_q      (adc_q),
            .iq_out_V   (u_if),
            .clr_ovf    (clr_ovf),
            .ovf_sticky (sticky_o[gi]),
            .ovf_count  (ovfcnt_o[gi]),
            .state_o    (state_out[gi])
         );
      end
   endgenerate

   // ---------------------------------------------------------------- model
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_fifo [NDUT][$];
   int          m_mode [NDUT];     // 0 idle, 1 prime, 2 run
   int          m_seen [NDUT];     // strobes seen since entering prime
   bit          m_st1_v [NDUT];
   logic [31:0] m_st1_d [NDUT];
   int          m_ovf [NDUT];
   bit          m_sticky [NDUT];
   longint      m_acc [NDUT][2];
   logic [31:0] rec [$];
   bit          rec_on = 1'b0;

   function automatic int prime_of(input int k);
      return (k == 0) ? 0 : 16;
   endfunction

   function automatic longint wrap26(input longint v);
      longint t;
      t = v & ((64'sd1 <<< 26) - 1);
      if (t >= (64'sd1 <<< 25)) t = t - (64'sd1 <<< 26);
      return t;
   endfunction

   function automatic logic [15:0] model_y(input int k, input int ch, input int x);
      longint s;
      longint yu;
      s  = longint'(x) * (64'sd1 <<< (16 - ADC_W));
      yu = s;
`ifdef IQ_IN_DC_REMOVE_EN
      yu = s - (m_acc[k][ch] >>> 10);
      if (yu > 32767) yu = 32767;
      else if (yu < -32768) yu = -32768;
`endif
      return 16'(yu);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_fifo[k].delete();
         m_mode[k]   = 0;
         m_seen[k]   = 0;
         m_st1_v[k]  = 1'b0;
         m_st1_d[k]  = '0;
         m_ovf[k]    = 0;
         m_sticky[k] = 1'b0;
         m_acc[k][0] = 0;
         m_acc[k][1] = 0;
      end
   endtask

   task automatic model_step();
      bit do_pop;
      bit accept;
      bit dropped;
      if (!ap_rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NDUT; k++) begin
         do_pop  = (m_fifo[k].size() > 0) && tready;
         accept  = m_st1_v[k] && ((m_fifo[k].size() < DEPTH) || do_pop);
         dropped = m_st1_v[k] && !accept;
         if (do_pop) void'(m_fifo[k].pop_front());
         if (accept) m_fifo[k].push_back(m_st1_d[k]);
         if (clr_ovf) begin
            m_ovf[k]    = dropped ? 1 : 0;
            m_sticky[k] = dropped;
         end else if (dropped) begin
            m_sticky[k] = 1'b1;
            if (m_ovf[k] < 65535) m_ovf[k]++;
         end
         m_st1_v[k] = adc_valid && en && (m_mode[k] == 2);
         if (m_st1_v[k]) m_st1_d[k] = {model_y(k, 1, int'(adc_q)), model_y(k, 0, int'(adc_i))};
         for (int ch = 0; ch < 2; ch++) begin
            longint s;
            longint dc;
            s  = longint'((ch == 0) ? int'(adc_i) : int'(adc_q)) * (64'sd1 <<< (16 - ADC_W));
            dc = m_acc[k][ch] >>> 10;
            if (!en) m_acc[k][ch] = 0;
            else if (adc_valid && m_mode[k] != 0) m_acc[k][ch] = wrap26(m_acc[k][ch] + (s - dc) - dc);
         end
         if (!en) begin
            m_mode[k] = 0;
         end else if (m_mode[k] == 0) begin
            m_seen[k] = 0;
            m_mode[k] = (prime_of(k) == 0) ? 2 : 1;
         end else if (m_mode[k] == 1 && adc_valid) begin
            m_seen[k]++;
            if (m_seen[k] >= prime_of(k)) m_mode[k] = 2;
         end
      end
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NDUT; k++) begin
         chk("tvalid", k, 32'(tvalid_o[k]), 32'(m_fifo[k].size() > 0));
         if (m_fifo[k].size() > 0) chk("tdata", k, tdata_o[k], m_fifo[k][0]);
         chk("state", k, 32'(state_out[k]), m_mode[k]);
         chk("ovf_sticky", k, 32'(sticky_o[k]), 32'(m_sticky[k]));
         chk("ovf_count", k, 32'(ovfcnt_o[k]), m_ovf[k]);
      end
   endtask

   // Called between edges with the inputs for the coming edge already set.
   task automatic tick();
      if (rec_on && tvalid_o[1] && tready) rec.push_back(tdata_o[1]);
      @(posedge ap_clk);
      model_step();
      @(negedge ap_clk);
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      model_reset();
      ticks(3);
      for (int k = 0; k < NDUT; k++) begin
         chk("rst_tvalid", k, 32'(tvalid_o[k]), 32'd0);
         chk("rst_tdata", k, tdata_o[k], 32'd0);
         chk("rst_state", k, 32'(state_out[k]), 32'd0);
         chk("rst_ovf", k, 32'(ovfcnt_o[k]), 32'd0);
      end
      ap_rst_n = 1'b1;

      // Scaling and latency
      en = 1'b1; tready = 1'b1;
      ticks(10);
      adc_valid = 1'b1; adc_i = 12'sh7FF; adc_q = 12'sh800;
      tick();
      adc_valid = 1'b0;
      chk("lat_n1_tvalid", 0, 32'(tvalid_o[0]), 32'd0);
      tick();
      chk("lat_n2_tvalid", 0, 32'(tvalid_o[0]), 32'd1);
`ifndef IQ_IN_DC_REMOVE_EN
      chk("scale_tdata", 0, tdata_o[0], 32'h8000_7FF0);
`endif
      ticks(4);

      // Prime: fresh enable, 20 strobes, instance 1 must pass only the last 4
      en = 1'b0; tick();
      en = 1'b1; tick();
      rec.delete(); rec_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         adc_valid = 1'b1; adc_i = ADC_W'(i); adc_q = '0;
         tick();
         if (i == 14) chk("prime_state15", 1, 32'(state_out[1]), 32'd1);
         if (i == 15) chk("prime_state16", 1, 32'(state_out[1]), 32'd2);
      end
      adc_valid = 1'b0;
      ticks(12);
      rec_on = 1'b0;
      chk("prime_beats", 1, rec.size(), 32'd4);
`ifndef IQ_IN_DC_REMOVE_EN
      for (int j = 0; j < 4 && j < rec.size(); j++) chk("prime_data", 1, rec[j], 32'((16 + j) << 4));
`endif

      // Overflow: 12 strobes into a stalled 8-deep FIFO
      tready = 1'b0; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      for (int i = 0; i < 12; i++) begin
         adc_valid = 1'b1; adc_i = ADC_W'(100 + i);
         tick();
      end
      adc_valid = 1'b0;
      ticks(2);
      for (int k = 0; k < NDUT; k++) begin
         chk("ovf_count4", k, 32'(ovfcnt_o[k]), 32'd4);
         chk("ovf_sticky1", k, 32'(sticky_o[k]), 32'd1);
      end
      rec.delete(); rec_on = 1'b1; tready = 1'b1;
      ticks(12);
      rec_on = 1'b0;
      chk("ovf_beats", 1, rec.size(), 32'd8);
`ifndef IQ_IN_DC_REMOVE_EN
      for (int j = 0; j < 8 && j < rec.size(); j++) chk("ovf_order", 1, rec[j], 32'((100 + j) << 4));
`endif
      chk("ovf_drained", 0, 32'(tvalid_o[0]), 32'd0);

      // Full FIFO with simultaneous push and pop
      tready = 1'b0; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      for (int i = 0; i < 9; i++) begin
         adc_valid = 1'b1; adc_i = ADC_W'(200 + i);
         tick();
      end
      adc_valid = 1'b0; tready = 1'b1;
      rec.delete(); rec_on = 1'b1;
      tick();
      chk("pushpop_ovf", 0, 32'(ovfcnt_o[0]), 32'd0);
      tready = 1'b0; ticks(2);
      tready = 1'b1; ticks(12);
      rec_on = 1'b0;
      chk("pushpop_beats", 1, rec.size(), 32'd9);

      // Counter saturation, then clear colliding with a drop
      tready = 1'b0; adc_valid = 1'b1;
      ticks(65550);
      for (int k = 0; k < NDUT; k++) chk("ovf_sat", k, 32'(ovfcnt_o[k]), 32'h0000_FFFF);
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      for (int k = 0; k < NDUT; k++) chk("clr_with_drop", k, 32'(ovfcnt_o[k]), 32'd1);
      adc_valid = 1'b0;

      // Asynchronous reset between edges with data queued
      ticks(3);
      #2 ap_rst_n = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < NDUT; k++) begin
         chk("async_tvalid", k, 32'(tvalid_o[k]), 32'd0);
         chk("async_state", k, 32'(state_out[k]), 32'd0);
      end
      en = 1'b0;
      ticks(2);
      ap_rst_n = 1'b1; tready = 1'b1; adc_valid = 1'b1;
      ticks(5);
      chk("post_rst_idle", 0, 32'(tvalid_o[0]), 32'd0);
      en = 1'b1;
      ticks(4);
      chk("post_rst_prime", 1, 32'(state_out[1]), 32'd1);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(99) < 97);
         adc_valid = $urandom_range(1) == 1;
         adc_i     = ADC_W'($urandom);
         adc_q     = ADC_W'($urandom);
         tready    = ($urandom_range(3) != 0);
         clr_ovf   = ($urandom_range(63) == 0);
         tick();
      end
      adc_valid = 1'b0; clr_ovf = 1'b0; tready = 1'b1;
      ticks(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
